// File: rtl/spike_dispatch_scheduler_if.sv
// Handshake and fanout-lookup bundle between the dispatch scheduler and its neighbours.
// master = scheduler side; slave = accelerator, fanout memory, local sink and router side.
interface spike_dispatch_scheduler_if #(
    parameter int NUM_BITS_ADDR   = 12,
    parameter int NUM_CONNECTIONS = 5
);
    logic                                     spike_valid;
    logic [NUM_BITS_ADDR-1:0]                 spike_addr;
    logic                                     spike_ready;

    logic [NUM_BITS_ADDR-1:0]                 fo_src_addr;
    logic [NUM_BITS_ADDR*NUM_CONNECTIONS-1:0] fo_dest_addr;

    logic                                     local_valid;
    logic [NUM_BITS_ADDR-1:0]                 local_addr;
    logic                                     local_ready;

    logic                                     pkt_valid;
    logic [NUM_BITS_ADDR-1:0]                 pkt_src;
    logic [NUM_BITS_ADDR-1:0]                 pkt_dest;
    logic                                     pkt_ready;

    logic                                     busy;
    logic [15:0]                              local_count;
    logic [15:0]                              remote_count;

    modport master (
        input  spike_valid, spike_addr, fo_dest_addr, local_ready, pkt_ready,
        output spike_ready, fo_src_addr, local_valid, local_addr,
               pkt_valid, pkt_src, pkt_dest, busy, local_count, remote_count
    );

    modport slave (
        output spike_valid, spike_addr, fo_dest_addr, local_ready, pkt_ready,
        input  spike_ready, fo_src_addr, local_valid, local_addr,
               pkt_valid, pkt_src, pkt_dest, busy, local_count, remote_count
    );
endinterface

// File: rtl/spike_dispatch_scheduler.sv
// Buffers spike events, looks up their fanout entry and routes each destination slot locally or to the network.
// Define DISPATCH_STATS_EN to build the saturating local/remote dispatch counters.
module spike_dispatch_scheduler #(
    parameter int NUM_BITS_ADDR   = 12,
    parameter int NUM_CONNECTIONS = 5,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    spike_dispatch_scheduler_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = (NUM_CONNECTIONS > 1) ? $clog2(NUM_CONNECTIONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONNECTIONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_DISPATCH
    } state_t;

    state_t                                   r_state;
    state_t                                   w_nextState;
    logic [NUM_BITS_ADDR-1:0]                 r_fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]                         r_wrPtr;
    logic [PTR_W-1:0]                         r_rdPtr;
    logic [NUM_BITS_ADDR-1:0]                 r_srcAddr;
    logic [NUM_BITS_ADDR*NUM_CONNECTIONS-1:0] r_destReg;
    logic [IDX_W-1:0]                         r_idx;

    logic                                     w_fifoFull;
    logic                                     w_fifoEmpty;
    logic                                     w_push;
    logic                                     w_pop;
    logic                                     w_loadDest;
    logic                                     w_advance;
    logic                                     w_localValid;
    logic                                     w_pktValid;
    logic [NUM_BITS_ADDR-1:0]                 w_slots [NUM_CONNECTIONS];
    logic [NUM_BITS_ADDR-1:0]                 w_slot;
    logic                                     w_slotNull;
    logic                                     w_slotLocal;

    // The extra pointer bit distinguishes a full FIFO from an empty one.
    assign w_fifoEmpty = (r_wrPtr == r_rdPtr);
    assign w_fifoFull  = (r_wrPtr[PTR_W-1] != r_rdPtr[PTR_W-1]) &&
                         (r_wrPtr[PTR_W-2:0] == r_rdPtr[PTR_W-2:0]);
    assign w_push      = bus.spike_valid && !w_fifoFull;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr[PTR_W-2:0]] <= bus.spike_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CONNECTIONS; k++) begin : g_slots
        assign w_slots[k] = r_destReg[k*NUM_BITS_ADDR +: NUM_BITS_ADDR];
    end

    assign w_slot      = w_slots[r_idx];
    assign w_slotNull  = &w_slot;
    assign w_slotLocal = (w_slot[NUM_BITS_ADDR-1:NUM_BITS_ADDR-2] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_pop        = 1'b0;
        w_loadDest   = 1'b0;
        w_localValid = 1'b0;
        w_pktValid   = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifoEmpty) begin
                    w_pop       = 1'b1;
                    w_nextState = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                w_loadDest  = 1'b1;
                w_nextState = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                w_localValid = !w_slotNull && w_slotLocal;
                w_pktValid   = !w_slotNull && !w_slotLocal;
                // Null slots advance unconditionally; real slots wait for their handshake.
                w_advance    = w_slotNull ||
                               (w_localValid && bus.local_ready) ||
                               (w_pktValid && bus.pkt_ready);
                if (w_advance && (r_idx == '0)) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_srcAddr <= '0;
            r_destReg <= '0;
            r_idx     <= '0;
        end else begin
            if (w_pop) begin
                r_srcAddr <= r_fifoMem[r_rdPtr[PTR_W-2:0]];
            end
            if (w_loadDest) begin
                r_destReg <= bus.fo_dest_addr;
                r_idx     <= LAST_IDX;
            end else if (w_advance && (r_idx != '0)) begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

    assign bus.spike_ready = !w_fifoFull;
    assign bus.fo_src_addr = r_srcAddr;
    assign bus.local_valid = w_localValid;
    assign bus.local_addr  = w_localValid ? w_slot : '0;
    assign bus.pkt_valid   = w_pktValid;
    assign bus.pkt_src     = w_pktValid ? r_srcAddr : '0;
    assign bus.pkt_dest    = w_pktValid ? w_slot : '0;
    assign bus.busy        = !w_fifoEmpty || (r_state != ST_IDLE);

`ifdef DISPATCH_STATS_EN
    logic [15:0] r_localCount;
    logic [15:0] r_remoteCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_localCount  <= '0;
            r_remoteCount <= '0;
        end else begin
            if (w_localValid && bus.local_ready && (r_localCount != 16'hFFFF)) begin
                r_localCount <= r_localCount + 16'd1;
            end
            if (w_pktValid && bus.pkt_ready && (r_remoteCount != 16'hFFFF)) begin
                r_remoteCount <= r_remoteCount + 16'd1;
            end
        end
    end

    assign bus.local_count  = r_localCount;
    assign bus.remote_count = r_remoteCount;
`else
    assign bus.local_count  = '0;
    assign bus.remote_count = '0;
`endif
endmodule
